// File: rtl/rv_pkg.sv
// Shared RV core definitions: datapath widths, default reset PC, fetch FSM states.
package rv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single outstanding imem fetch, decoder handshake,
// aligned redirects with stale-response discard, misaligned-redirect pulse.
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    output logic            misaligned_err
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic            discard_q, discard_d;
    logic            err_q, err_d;
    logic            redir_ok;
    logic            redir_bad;

    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH_REQ;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        err_d      = redir_bad;

        if (redir_ok) pc_d = redirect_pc;

        case (state_q)
            FETCH_REQ: begin
                // A request accepted alongside a redirect is stale: wait out its
                // response with discard set so only one fetch is ever in flight.
                if (imem_req_ready) begin
                    state_d   = FETCH_WAIT;
                    discard_d = redir_ok;
                end
            end
            FETCH_WAIT: begin
                if (redir_ok) begin
                    if (imem_rsp_valid) begin
                        state_d   = FETCH_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (discard_q) begin
                        state_d   = FETCH_REQ;
                        discard_d = 1'b0;
                    end else begin
                        instr_d    = imem_rsp_data;
                        instr_pc_d = pc_q;
                        state_d    = FETCH_HOLD;
                    end
                end
            end
            FETCH_HOLD: begin
                if (redir_ok) begin
                    state_d = FETCH_REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    assign imem_req_valid = rst_n && (state_q == FETCH_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == FETCH_HOLD);
    assign instruction    = instr_q;
    assign instr_pc       = instr_pc_q;
    assign misaligned_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run against an
// architectural-PC reference model and a single-outstanding memory model.
module tb_instr_fetch;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
    logic        misaligned_err;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .misaligned_err (misaligned_err)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of the byte address.
    function automatic logic [31:0] memword(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid);
        end
        checks++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0 || instr_pc !== RESET_PC || misaligned_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b ins=%h pc=%h err=%b exp v=0 ins=0 pc=%h err=0",
                     instr_valid, instruction, instr_pc, misaligned_err, RESET_PC);
        end
    endtask

    task automatic test_basic_fetch();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
            failures++; $display("FAIL first_req got v=%b addr=%h exp v=1 addr=0", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL wait_no_req got=%b exp=0", imem_req_valid);
        end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instruction !== 32'h0050_0093 || instr_pc !== 64'h0) begin
            failures++;
            $display("FAIL first_instr got v=%b ins=%h pc=%h exp v=1 ins=00500093 pc=0", instr_valid, instruction, instr_pc);
        end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instruction !== 32'h0050_0093 || instr_pc !== 64'h0 || imem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable cycle=%0d got v=%b ins=%h pc=%h req=%b exp v=1 ins=00500093 pc=0 req=0",
                         i, instr_valid, instruction, instr_pc, imem_req_valid);
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL next_req got req=%b addr=%h v=%b exp req=1 addr=4 v=0", imem_req_valid, imem_req_addr, instr_valid);
        end
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1000;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL redir_wait_no_req got=%b exp=0", imem_req_valid);
        end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
            failures++;
            $display("FAIL redir_wait got v=%b req=%b addr=%h exp v=0 req=1 addr=1000", instr_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_hold();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h1000 || instruction !== 32'h1111_1111) begin
            failures++;
            $display("FAIL fetch_1000 got v=%b pc=%h ins=%h exp v=1 pc=1000 ins=11111111", instr_valid, instr_pc, instruction);
        end
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        @(negedge clk);
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_hold got req=%b addr=%h v=%b exp req=1 addr=2000 v=0", imem_req_valid, imem_req_addr, instr_valid);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1002;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (misaligned_err !== 1'b1 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin
            failures++;
            $display("FAIL misaligned_pulse got err=%b req=%b addr=%h exp err=1 req=1 addr=2000",
                     misaligned_err, imem_req_valid, imem_req_addr);
        end
        @(negedge clk);
        checks++;
        if (misaligned_err !== 1'b0) begin
            failures++; $display("FAIL misaligned_one_cycle got=%b exp=0", misaligned_err);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2222_2222;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h2000) begin
            failures++; $display("FAIL misaligned_stream got v=%b pc=%h exp v=1 pc=2000", instr_valid, instr_pc);
        end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_req got=%b exp=0", imem_req_valid);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0 || instr_pc !== RESET_PC || misaligned_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got v=%b ins=%h pc=%h err=%b exp v=0 ins=0 pc=%h err=0",
                     instr_valid, instruction, instr_pc, misaligned_err, RESET_PC);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            failures++;
            $display("FAIL rst_mid_refetch got req=%b addr=%h exp req=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_pc, mem_addr, tgt, sv_pc;
        logic [31:0] sv_ins;
        logic        outst, exp_err, post_rst, keep, redir_ok;
        int          delay;
        int          consumed;

        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        exp_pc   = RESET_PC;
        mem_addr = '0;
        sv_pc    = '0;
        sv_ins   = '0;
        outst    = 1'b0;
        exp_err  = 1'b0;
        post_rst = 1'b1;
        keep     = 1'b0;
        delay    = 0;
        consumed = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            checks++;
            if (misaligned_err !== exp_err) begin
                failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, misaligned_err, exp_err);
            end
            if (post_rst) begin
                checks++;
                if (instr_valid !== 1'b0 || instruction !== 32'h0 || instr_pc !== RESET_PC) begin
                    failures++;
                    $display("FAIL rnd_reset cyc=%0d got v=%b ins=%h pc=%h exp v=0 ins=0 pc=%h",
                             cyc, instr_valid, instruction, instr_pc, RESET_PC);
                end
            end
            if (keep) begin
                checks++;
                if (instr_valid !== 1'b1 || instruction !== sv_ins || instr_pc !== sv_pc) begin
                    failures++;
                    $display("FAIL rnd_hold cyc=%0d got v=%b ins=%h pc=%h exp v=1 ins=%h pc=%h",
                             cyc, instr_valid, instruction, instr_pc, sv_ins, sv_pc);
                end
            end

            rst_n          = ($urandom_range(0, 99) != 0);
            imem_req_ready = 1'($urandom_range(0, 1));
            instr_ready    = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                1: begin
                    tgt = {$urandom, $urandom};
                    tgt[1:0] = 2'($urandom_range(1, 3));
                end
                default: begin
                    tgt = {$urandom, $urandom};
                    tgt[1:0] = 2'b00;
                end
            endcase
            redirect_pc = tgt;

            if (!rst_n) begin
                imem_rsp_valid = 1'b0;
                outst = 1'b0;
            end else if (outst && delay == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memword(mem_addr);
                outst = 1'b0;
            end else begin
                if (outst) delay--;
                imem_rsp_valid = !outst && ($urandom_range(0, 7) == 0);
                imem_rsp_data  = $urandom;
            end

            #1;
            if (!rst_n) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    failures++; $display("FAIL rnd_rst_req cyc=%0d got=%b exp=0", cyc, imem_req_valid);
                end
            end else if (imem_req_valid) begin
                checks++;
                if (imem_req_addr !== exp_pc) begin
                    failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_pc);
                end
            end

            redir_ok = rst_n && redirect_valid && (tgt[1:0] == 2'b00);
            keep     = rst_n && (instr_valid === 1'b1) && !instr_ready && !redir_ok;
            sv_ins   = instruction;
            sv_pc    = instr_pc;

            if (rst_n && !redir_ok && instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instruction !== memword(exp_pc)) begin
                    failures++;
                    $display("FAIL rnd_instr cyc=%0d got pc=%h ins=%h exp pc=%h ins=%h",
                             cyc, instr_pc, instruction, exp_pc, memword(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
                consumed++;
            end
            if (redir_ok) exp_pc = tgt;

            if (rst_n && imem_req_valid && imem_req_ready) begin
                checks++;
                if (outst) begin
                    failures++; $display("FAIL rnd_outstanding cyc=%0d got=2 exp<=1", cyc);
                end
                outst    = 1'b1;
                mem_addr = imem_req_addr;
                delay    = int'($urandom_range(0, 3));
            end

            if (!rst_n) exp_pc = RESET_PC;
            exp_err  = rst_n && redirect_valid && (tgt[1:0] != 2'b00);
            post_rst = !rst_n;
        end

        checks++;
        if (consumed < 50) begin
            failures++; $display("FAIL rnd_progress got=%0d exp>=50", consumed);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_0000_0000, giving the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-005 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-006 SHALL have port imem_req_addr, output, 64 bits: fetch byte address, equal to the current PC.
REQ-007 SHALL have port imem_rsp_valid, input, 1 bit: response data valid.
REQ-008 SHALL have port imem_rsp_data, input, 32 bits: fetched instruction word.
REQ-009 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-010 SHALL have port redirect_pc, input, 64 bits: redirect target address.
REQ-011 SHALL have port instr_valid, output, 1 bit: instruction output valid toward the decoder.
REQ-012 SHALL have port instr_ready, input, 1 bit: decoder consumes the instruction.
REQ-013 SHALL have port instruction, output, 32 bits: instruction word for the decoder.
REQ-014 SHALL have port instr_pc, output, 64 bits: PC of the presented instruction.
REQ-015 SHALL have port misaligned_err, output, 1 bit: one-cycle pulse flagging a rejected misaligned redirect.

Function
REQ-016 SHALL implement FSM states REQ, WAIT and HOLD, with at most one outstanding fetch.
REQ-017 SHALL, in REQ, drive imem_req_valid=1 and hold imem_req_addr stable until accepted; on imem_req_ready, go to WAIT.
REQ-018 SHALL, in WAIT, on imem_rsp_valid, register imem_rsp_data into instruction and the PC into instr_pc, then go to HOLD.
REQ-019 SHALL, in HOLD, drive instr_valid=1; on instr_ready, set PC to PC+4 (64-bit, modulo 2^64) and go to REQ.
REQ-020 SHALL give a minimum latency of 3 cycles from request acceptance to the next request: WAIT, HOLD, then REQ.
REQ-021 SHALL, on redirect_valid with redirect_pc[1:0]==2'b00, load PC with redirect_pc; redirect has priority over every other event in the same cycle.
REQ-022 SHALL, on a redirect in REQ, stay in REQ and present the new address next cycle; a request accepted in that same cycle is treated as stale.
REQ-023 SHALL, on a redirect in WAIT (or a stale accept per REQ-022), set a discard flag, drop the next response, clear the flag and go to REQ with the redirected PC.
REQ-024 SHALL, on a redirect in HOLD, drop the held instruction (instr_valid=0 next cycle) and go to REQ; with simultaneous instr_ready the instruction counts as consumed and PC=redirect_pc, not PC+4.
REQ-025 SHALL, on redirect_valid with redirect_pc[1:0]!=2'b00, ignore the redirect, leave PC and state unchanged, and pulse misaligned_err for exactly one cycle.
REQ-026 SHALL ignore imem_rsp_valid outside WAIT.
REQ-027 SHALL keep instruction and instr_pc stable while instr_valid=1.

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, set PC=RESET_PC, state=REQ, discard flag=0, instr_valid=0, instruction=32'h0, instr_pc=RESET_PC, misaligned_err=0.
REQ-029 SHALL hold imem_req_valid=0 in every cycle where rst_n=0, and assert it in the first cycle after rst_n rises.
REQ-030 SHALL abandon any in-flight fetch when reset occurs mid-operation; the memory shares rst_n and drops its response.

Structure
REQ-031 SHALL take XLEN=64, ILEN=32, the default RESET_PC and the fetch-state enum from shared package rv_pkg.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 Reset release, ready=1, rsp one cycle after accept -> first imem_req_addr=0x0; instruction 0x00500093 presented with instr_pc=0x0; next request addr=0x4.
REQ-034 instr_ready held 0 for 5 cycles in HOLD -> instr_valid, instruction and instr_pc stable; no new request issued.
REQ-035 Redirect to 0x1000 while in WAIT -> old response dropped, next request addr=0x1000, no instr_valid for the stale word.
REQ-036 Redirect to 0x2000 together with instr_ready in HOLD -> next request addr=0x2000, not PC+4.
REQ-037 Redirect to 0x1002 -> misaligned_err high exactly 1 cycle, PC and fetch stream unchanged.
REQ-038 rst_n low for 1 cycle during WAIT -> all outputs at reset values next cycle, then refetch from RESET_PC.
